// File: rtl/quad_decoder_if.sv
// ---------------------------------------------------------------------------
// quad_decoder_if -- signal bundle between a quadrature encoder front end and
// the decoder.
//   a_in, b_in : encoder channels A/B (asynchronous to the decoder clock)
//   err_clr    : synchronous clear of the sticky err flag
//   en         : one-cycle step pulse for the downstream counter
//   up_dwn_n   : direction of the latest step (1 = up, 0 = down)
//   err        : sticky illegal-transition flag
// Modports: master drives the channels and err_clr; slave is the decoder.
// ---------------------------------------------------------------------------
interface quad_decoder_if;
  logic a_in;
  logic b_in;
  logic err_clr;
  logic en;
  logic up_dwn_n;
  logic err;

  modport master (output a_in, b_in, err_clr, input en, up_dwn_n, err);
  modport slave  (input a_in, b_in, err_clr, output en, up_dwn_n, err);
endinterface

// File: rtl/quad_decoder.sv
// ---------------------------------------------------------------------------
// quad_decoder -- quadrature (A/B) encoder decoder.
//
// Both channels pass through a two-flop synchronizer, optionally through a
// per-channel glitch filter, and are then compared against the last accepted
// state (prev). Legal one-bit moves produce a one-cycle en pulse plus
// direction; two-bit moves set a sticky err flag.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : quad_decoder_if.slave (a_in, b_in, err_clr in; en, up_dwn_n, err out)
//
// Parameter:
//   FILT_CYCLES : stable cycles the glitch filter requires (2..15)
//
// Build option:
//   QUAD_FILTER_EN : when defined, a glitch filter sits after the
//                    synchronizer; latency grows from 3 to 3 + FILT_CYCLES
//                    edges. When undefined, no filter flops exist.
//
// AB encoding internally: bit 1 = A, bit 0 = B.
// ---------------------------------------------------------------------------
module quad_decoder #(
  parameter int FILT_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  quad_decoder_if.slave  bus
);

  if (FILT_CYCLES < 2 || FILT_CYCLES > 15) begin : g_bad_filt_cycles
    $error("quad_decoder: FILT_CYCLES must be within 2..15");
  end

  // Forward order 00 -> 10 -> 11 -> 01 -> 00; reverse is the inverse map.
  function automatic logic [1:0] fwd_next(input logic [1:0] ab);
    case (ab)
      2'b00:   fwd_next = 2'b10;
      2'b10:   fwd_next = 2'b11;
      2'b11:   fwd_next = 2'b01;
      default: fwd_next = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] rev_next(input logic [1:0] ab);
    case (ab)
      2'b00:   rev_next = 2'b01;
      2'b01:   rev_next = 2'b11;
      2'b11:   rev_next = 2'b10;
      default: rev_next = 2'b00;
    endcase
  endfunction

  // Synchronizer plus a valid pipeline that marks when sync2 holds a real
  // sample rather than its reset value, so start-up never looks like a move.
  logic [1:0] sync1_q, sync1_d;
  logic [1:0] sync2_q, sync2_d;
  logic [1:0] vld_q,   vld_d;

  logic [1:0] cur_ab;
  logic       cur_vld;

  logic [1:0] prev_q,     prev_d;
  logic       init_q,     init_d;
  logic       en_q,       en_d;
  logic       up_dwn_n_q, up_dwn_n_d;
  logic       err_q,      err_d;

  assign sync1_d = {bus.a_in, bus.b_in};
  assign sync2_d = sync1_q;
  assign vld_d   = {vld_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, whatever the block order.
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      vld_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      vld_q   <= vld_d;
    end
  end

`ifdef QUAD_FILTER_EN
  localparam logic [3:0] FILT_LAST = 4'(FILT_CYCLES - 1);

  logic [1:0]      flt_q,     flt_d;
  logic            flt_vld_q, flt_vld_d;
  logic [1:0][3:0] cnt_q,     cnt_d;

  always_comb begin
    flt_d     = flt_q;
    flt_vld_d = flt_vld_q;
    cnt_d     = cnt_q;
    if (!flt_vld_q) begin
      // First real sample seeds the filter directly instead of being filtered
      // up from the reset value.
      if (vld_q[1]) begin
        flt_d     = sync2_q;
        flt_vld_d = 1'b1;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == flt_q[i]) begin
          cnt_d[i] = '0;                 // level returned: discard partial count
        end else if (cnt_q[i] == FILT_LAST) begin
          flt_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flt_q     <= '0;
      flt_vld_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      flt_q     <= flt_d;
      flt_vld_q <= flt_vld_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cur_ab  = flt_q;
  assign cur_vld = flt_vld_q;
`else
  assign cur_ab  = sync2_q;
  assign cur_vld = vld_q[1];
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    prev_d     = prev_q;
    init_d     = init_q;
    en_d       = 1'b0;
    up_dwn_n_d = up_dwn_n_q;
    err_d      = err_q;
    if (bus.err_clr) err_d = 1'b0;
    if (!init_q) begin
      if (cur_vld) begin
        prev_d = cur_ab;
        init_d = 1'b1;
      end
    end else if (cur_ab != prev_q) begin
      prev_d = cur_ab;
      if (cur_ab == fwd_next(prev_q)) begin
        en_d       = 1'b1;
        up_dwn_n_d = 1'b1;
      end else if (cur_ab == rev_next(prev_q)) begin
        en_d       = 1'b1;
        up_dwn_n_d = 1'b0;
      end else begin
        err_d = 1'b1;                    // overrides a same-cycle err_clr
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= '0;
      init_q     <= 1'b0;
      en_q       <= 1'b0;
      up_dwn_n_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      init_q     <= init_d;
      en_q       <= en_d;
      up_dwn_n_q <= up_dwn_n_d;
      err_q      <= err_d;
    end
  end

  assign bus.en       = en_q;
  assign bus.up_dwn_n = up_dwn_n_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// ---------------------------------------------------------------------------
// tb_quad_decoder -- directed bench for quad_decoder.
// Inputs change and outputs are sampled on the falling clock edge.
// Compile with +define+QUAD_FILTER_EN to exercise the glitch filter build.
// ---------------------------------------------------------------------------
module tb_quad_decoder;

  localparam int FILT = 4;
`ifdef QUAD_FILTER_EN
  localparam int LAT = 3 + FILT;
`else
  localparam int LAT = 3;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  quad_decoder_if bus ();

  quad_decoder #(.FILT_CYCLES(FILT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream up/down counter fed by en / up_dwn_n.
  logic [3:0] cnt_model;
  logic       cnt_clr;
  always @(posedge clk) begin
    if (cnt_clr)     cnt_model <= 4'h0;
    else if (bus.en) cnt_model <= bus.up_dwn_n ? cnt_model + 4'h1 : cnt_model - 4'h1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_ab(input logic [1:0] ab);
    bus.a_in = ab[1];
    bus.b_in = ab[0];
  endtask

  // Apply one legal step and check the single en pulse LAT edges later.
  task automatic step(input string tag, input logic [1:0] ab, input logic exp_up);
    drive_ab(ab);
    tick(LAT - 1);
    check({tag, "_early"}, 32'(bus.en), 32'd0);
    tick(1);
    check({tag, "_en"}, 32'(bus.en), 32'd1);
    check({tag, "_dir"}, 32'(bus.up_dwn_n), 32'(exp_up));
    tick(1);
    check({tag, "_one"}, 32'(bus.en), 32'd0);
    tick(1);
  endtask

  // No en pulse anywhere in an n-cycle window.
  task automatic quiet(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    repeat (n) begin
      tick(1);
      seen = seen | bus.en;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [1:0] seq [4];
    logic [7:0] hist;
    checks      = 0;
    errors      = 0;
    cnt_clr     = 1'b0;
    rst_n       = 1'b0;
    bus.err_clr = 1'b0;
    drive_ab(2'b11);
    tick(2);
    check("rst_en",  32'(bus.en),       32'd0);
    check("rst_dir", 32'(bus.up_dwn_n), 32'd0);
    check("rst_err", 32'(bus.err),      32'd0);

    // AB held at 11 through reset release: init only, no en, no err.
    rst_n = 1'b1;
    quiet("init11_quiet", 12);
    check("init11_err", 32'(bus.err), 32'd0);
    step("init11_prev", 2'b01, 1'b1);      // 11 -> 01 is up only if prev = 11
    step("to00", 2'b00, 1'b1);

    // Forward sequence.
    step("fwd10", 2'b10, 1'b1);
    step("fwd11", 2'b11, 1'b1);
    step("fwd01", 2'b01, 1'b1);
    step("fwd00", 2'b00, 1'b1);

    // Reverse sequence into the counter model: 0 - 3 = D.
    cnt_clr = 1'b1;
    tick(1);
    cnt_clr = 1'b0;
    step("rev01", 2'b01, 1'b0);
    step("rev11", 2'b11, 1'b0);
    step("rev10", 2'b10, 1'b0);
    check("rev_cnt", 32'(cnt_model), 32'hD);

`ifndef QUAD_FILTER_EN
    // Back-to-back steps on consecutive cycles: four adjacent pulses.
    seq = '{2'b11, 2'b01, 2'b00, 2'b10};
    hist = '0;
    for (int t = 0; t < 8; t++) begin
      if (t < 4) drive_ab(seq[t]);
      tick(1);
      hist[t] = bus.en;
    end
    check("b2b_pulses", 32'(hist), 32'h3C);
    check("b2b_dir", 32'(bus.up_dwn_n), 32'd1);
    check("b2b_err", 32'(bus.err), 32'd0);
`endif

    // Direction reversal 10 -> 11 -> 10.
    step("revs_up", 2'b11, 1'b1);
    step("revs_dn", 2'b10, 1'b0);
    check("revs_err", 32'(bus.err), 32'd0);

    // Illegal jump 00 -> 11.
    step("ill_pre", 2'b00, 1'b0);
    drive_ab(2'b11);
    tick(LAT - 1);
    check("ill_early_err", 32'(bus.err), 32'd0);
    tick(1);
    check("ill_err", 32'(bus.err), 32'd1);
    check("ill_en", 32'(bus.en), 32'd0);
    check("ill_dir", 32'(bus.up_dwn_n), 32'd0);
    tick(2);
    check("ill_sticky", 32'(bus.err), 32'd1);
    check("ill_no_en", 32'(bus.en), 32'd0);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    check("clr_err", 32'(bus.err), 32'd0);

    // err_clr on the same edge as a second illegal jump 11 -> 00: set wins.
    drive_ab(2'b00);
    tick(LAT - 1);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    check("setwins_err", 32'(bus.err), 32'd1);
    check("setwins_en", 32'(bus.en), 32'd0);
    tick(2);
    check("setwins_sticky", 32'(bus.err), 32'd1);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    check("setwins_clr", 32'(bus.err), 32'd0);

    // Reset pulse while an en is out and another change is in flight.
    step("mid_pre", 2'b10, 1'b1);
    drive_ab(2'b11);
    tick(LAT - 1);
    drive_ab(2'b01);
    tick(1);
    check("mid_en_live", 32'(bus.en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_en",  32'(bus.en),       32'd0);
    check("mid_rst_dir", 32'(bus.up_dwn_n), 32'd0);
    check("mid_rst_err", 32'(bus.err),      32'd0);
    tick(1);
    rst_n = 1'b1;
    quiet("mid_post_quiet", LAT + 8);
    check("mid_post_err", 32'(bus.err), 32'd0);
    step("mid_post_step", 2'b00, 1'b1);   // 01 -> 00 up confirms prev reloaded

`ifdef QUAD_FILTER_EN
    // A glitch one cycle short of FILT is discarded.
    drive_ab(2'b10);
    tick(FILT - 1);
    drive_ab(2'b00);
    quiet("flt_glitch", 14);
    // Held for FILT cycles: one pulse, 3 + FILT edges after the change.
    step("flt_hold", 2'b10, 1'b1);
    check("flt_err", 32'(bus.err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
